// File: rtl/pc_fetch.sv
// Fetch PC register, imem req/ack fetcher and single-entry decode buffer.
// MISALIGN_TRAP_EN adds if_misalign and a HALT state on bit-1 targets.
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_c,
  input  logic [12:0] im_in,
  input  logic [31:0] br_pc,
  input  logic [31:0] jal_target,
  output logic [31:0] pc_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        if_ready
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        if_misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
`ifdef MISALIGN_TRAP_EN
    ,
    HALT
`endif
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pend_pc, pend_n;
  logic        kill, kill_n;
  logic        valid_q, valid_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] ipc_q, ipc_n;
  logic        redir;
  logic [31:0] target;

`ifdef MISALIGN_TRAP_EN
  logic        mis_q, mis_n;
`endif

  always_comb begin
    redir  = (pc_c == 2'd1) || (pc_c == 2'd2);
    target = (pc_c == 2'd1)
           ? (jal_target & 32'hFFFF_FFFE)
           : br_pc + {{19{im_in[12]}}, im_in};
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend_pc;
    kill_n  = kill;
    valid_n = valid_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
`ifdef MISALIGN_TRAP_EN
    mis_n   = mis_q;
`endif
    unique case (state)
      IDLE: begin
        state_n = FETCH;
        if (redir) pc_n = target;
      end
      FETCH: begin
        if (redir) begin
          // a redirect with ack in hand overrides any pending kill target
          if (imem_ack) begin
            pc_n   = target;
            kill_n = 1'b0;
          end else begin
            pend_n = target;
            kill_n = 1'b1;
          end
        end else if (imem_ack) begin
          if (kill) begin
            pc_n   = pend_pc;
            kill_n = 1'b0;
          end else begin
            valid_n = 1'b1;
            instr_n = imem_rdata;
            ipc_n   = pc;
            pc_n    = pc + 32'd4;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          pc_n    = target;
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          state_n = FETCH;
        end else if (valid_q && if_ready) begin
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          state_n = FETCH;
        end
      end
`ifdef MISALIGN_TRAP_EN
      HALT: begin
        state_n = HALT;
      end
`endif
      default: state_n = IDLE;
    endcase
`ifdef MISALIGN_TRAP_EN
    // bit-1 target: keep pc, drop everything in flight and park
    if (state != HALT && redir && target[1]) begin
      pc_n    = pc;
      pend_n  = pend_pc;
      kill_n  = 1'b0;
      valid_n = 1'b0;
      instr_n = NOP_INSTR;
      mis_n   = 1'b1;
      state_n = HALT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      pend_pc <= 32'd0;
      kill    <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'd0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
      kill    <= kill_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_n;
  end

  assign if_misalign = mis_q;
`endif

  assign pc_out    = pc;
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ipc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a latency-configurable imem model.
// Covers both builds of MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module tb_pc_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_c = 2'd0;
  logic [12:0] im_in = 13'd0;
  logic [31:0] br_pc = 32'd0;
  logic [31:0] jal_target = 32'd0;
  logic [31:0] pc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b1;
`ifdef MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  int checks = 0;
  int fails  = 0;
  int lat    = 0;
  int wcnt   = 0;

  pc_fetch #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc_c(pc_c), .im_in(im_in),
    .br_pc(br_pc), .jal_target(jal_target), .pc_out(pc_out),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready)
`ifdef MISALIGN_TRAP_EN
    , .if_misalign(if_misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  // wcnt counts wait cycles of the current request
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = mem_word(imem_addr);

  task automatic apply_reset(input int l);
    @(negedge clk);
    rst = 1'b1; pc_c = 2'd0; im_in = 13'd0;
    br_pc = 32'd0; jal_target = 32'd0;
    lat = l; if_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; lat = 3; if_ready = 1'b1; pc_c = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc_out !== RPC) begin
      fails++; $display("FAIL reset_pc: got %h expected %h", pc_out, RPC);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      fails++; $display("FAIL reset_req: got %b expected 0", imem_req);
    end
    checks++;
    if (if_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b expected 0", if_valid);
    end
    checks++;
    if (if_instr !== NOP) begin
      fails++; $display("FAIL reset_instr: got %h expected %h", if_instr, NOP);
    end
    checks++;
    if (if_pc !== 32'd0) begin
      fails++; $display("FAIL reset_ifpc: got %h expected 0", if_pc);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      fails++;
      $display("FAIL reset_first_fetch: got req %b addr %h expected 1 %h",
               imem_req, imem_addr, RPC);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc_out !== RPC) begin
      fails++;
      $display("FAIL reset_abandon: got req %b valid %b pc %h",
               imem_req, if_valid, pc_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] a;
    apply_reset(0);
    for (int k = 0; k < 3; k++) begin
      a = RPC + 32'(4 * k);
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0) begin
        fails++;
        $display("FAIL stream_addr%0d: got req %b addr %h valid %b expected addr %h",
                 k, imem_req, imem_addr, if_valid, a);
      end
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== a || if_instr !== mem_word(a)
          || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL stream_out%0d: got valid %b pc %h instr %h expected pc %h instr %h",
                 k, if_valid, if_pc, if_instr, a, mem_word(a));
      end
    end
  endtask

  task automatic test_hold();
    apply_reset(0);
    if_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== RPC
          || if_instr !== mem_word(RPC)) begin
        fails++;
        $display("FAIL hold_stable%0d: got req %b valid %b pc %h instr %h",
                 k, imem_req, if_valid, if_pc, if_instr);
      end
      if (k != 4) @(negedge clk);
    end
    if_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RPC + 32'd4) begin
      fails++;
      $display("FAIL hold_release: got valid %b req %b addr %h expected 0 1 %h",
               if_valid, imem_req, imem_addr, RPC + 32'd4);
    end
  endtask

  task automatic test_branch_kill();
    apply_reset(3);
    @(negedge clk);
    pc_c = 2'd2; br_pc = 32'h200; im_in = 13'h1FF8;
    @(negedge clk);
    pc_c = 2'd0;
    checks++;
    if (imem_addr !== RPC || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL bkill_addr_hold: got req %b addr %h expected 1 %h",
               imem_req, imem_addr, RPC);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin
      fails++; $display("FAIL bkill_no_valid: got %b expected 0", if_valid);
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h1F8 || imem_req !== 1'b1 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL bkill_new_addr: got req %b addr %h valid %b expected 1 1f8 0",
               imem_req, imem_addr, if_valid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h1F8) begin
      fails++;
      $display("FAIL bkill_deliver: got valid %b pc %h expected 1 1f8",
               if_valid, if_pc);
    end
  endtask

  task automatic test_jal_hold();
    apply_reset(0);
    repeat (2) @(negedge clk);
    pc_c = 2'd1; jal_target = 32'h0000_0301;
    @(negedge clk);
    pc_c = 2'd0;
    checks++;
    if (if_valid !== 1'b0 || if_instr !== NOP || imem_req !== 1'b1
        || imem_addr !== 32'h300) begin
      fails++;
      $display("FAIL jal_squash: got valid %b instr %h req %b addr %h expected 0 %h 1 300",
               if_valid, if_instr, imem_req, imem_addr, NOP);
    end
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h300) begin
      fails++;
      $display("FAIL jal_deliver: got valid %b pc %h expected 1 300", if_valid, if_pc);
    end
  endtask

  task automatic test_double_redirect();
    apply_reset(3);
    @(negedge clk);
    pc_c = 2'd1; jal_target = 32'h400;
    @(negedge clk);
    pc_c = 2'd2; br_pc = 32'h4F0; im_in = 13'h0010;
    @(negedge clk);
    pc_c = 2'd0;
    checks++;
    if (imem_addr !== RPC || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL dbl_hold: got addr %h valid %b expected %h 0",
               imem_addr, if_valid, RPC);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (imem_addr !== 32'h500 || imem_req !== 1'b1 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL dbl_latest: got req %b addr %h valid %b expected 1 500 0",
               imem_req, imem_addr, if_valid);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h500) begin
      fails++;
      $display("FAIL dbl_deliver: got valid %b pc %h expected 1 500", if_valid, if_pc);
    end
  endtask

  task automatic test_kill_ack_redirect();
    apply_reset(3);
    @(negedge clk);
    pc_c = 2'd1; jal_target = 32'h400;
    @(negedge clk);
    pc_c = 2'd0;
    repeat (2) @(negedge clk);
    pc_c = 2'd1; jal_target = 32'h600;
    @(negedge clk);
    pc_c = 2'd0;
    checks++;
    if (imem_addr !== 32'h600 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL killack_wins: got addr %h valid %b expected 600 0",
               imem_addr, if_valid);
    end
  endtask

  task automatic test_wrap();
    apply_reset(0);
    @(negedge clk);
    pc_c = 2'd2; br_pc = 32'hFFFF_FFFC; im_in = 13'h0008;
    @(negedge clk);
    pc_c = 2'd0;
    checks++;
    if (imem_addr !== 32'h4 || pc_out !== 32'h4 || imem_req !== 1'b1
        || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_addr: got req %b addr %h pc %h valid %b expected 1 4 4 0",
               imem_req, imem_addr, pc_out, if_valid);
    end
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4) begin
      fails++;
      $display("FAIL wrap_deliver: got valid %b pc %h expected 1 4", if_valid, if_pc);
    end
  endtask

  task automatic test_reserved();
    apply_reset(0);
    @(negedge clk);
    pc_c = 2'd3; jal_target = 32'h700;
    @(negedge clk);
    pc_c = 2'd0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== RPC || pc_out !== RPC + 32'd4) begin
      fails++;
      $display("FAIL reserved_cmd: got valid %b ifpc %h pc %h expected 1 %h %h",
               if_valid, if_pc, pc_out, RPC, RPC + 32'd4);
    end
  endtask

  task automatic test_misalign();
    apply_reset(0);
    @(negedge clk);
    pc_c = 2'd1; jal_target = 32'h0000_0402;
    @(negedge clk);
    pc_c = 2'd0;
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (if_misalign !== 1'b1 || imem_req !== 1'b0 || pc_out !== RPC
        || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL mis_trap: got mis %b req %b pc %h valid %b expected 1 0 %h 0",
               if_misalign, imem_req, pc_out, if_valid, RPC);
    end
    pc_c = 2'd1; jal_target = 32'h800;
    repeat (3) @(negedge clk);
    pc_c = 2'd0;
    checks++;
    if (if_misalign !== 1'b1 || imem_req !== 1'b0 || pc_out !== RPC) begin
      fails++;
      $display("FAIL mis_halt: got mis %b req %b pc %h expected 1 0 %h",
               if_misalign, imem_req, pc_out, RPC);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (if_misalign !== 1'b0 || pc_out !== RPC) begin
      fails++;
      $display("FAIL mis_reset: got mis %b pc %h expected 0 %h",
               if_misalign, pc_out, RPC);
    end
    rst = 1'b0;
`else
    checks++;
    if (imem_addr !== 32'h402 || imem_req !== 1'b1) begin
      fails++;
      $display("FAIL mis_verbatim: got req %b addr %h expected 1 402",
               imem_req, imem_addr);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_branch_kill();
    test_jal_hold();
    test_double_redirect();
    test_kill_ack_redirect();
    test_wrap();
    test_reserved();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Program-counter and instruction-fetch unit on the receiving end of the jump unit's redirect interface (pc_c / im_out / target).
- Holds the architectural fetch PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents one fetched instruction at a time to decode through a single-entry valid/ready output buffer.
- Applies jal and branch redirects, squashing in-flight or buffered wrong-path instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on if_instr when the buffer is empty or after reset

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
pc_c  input  2  redirect command: 0 = none, 1 = jal (target = jal_target), 2 = branch taken (target = br_pc + sext(im_in)), 3 = reserved, treated as 0
im_in  input  13  signed branch offset in bytes
br_pc  input  32  PC of the branch instruction
jal_target  input  32  absolute jump target
pc_out  output  32  current fetch PC register
imem_req  output  1  fetch request
imem_addr  output  32  fetch address, equals pc_out while imem_req=1
imem_ack  input  1  fetch complete; imem_rdata is valid in the same cycle
imem_rdata  input  32  fetched instruction word
if_valid  output  1  output buffer holds an instruction
if_instr  output  32  buffered instruction
if_pc  output  32  PC of the buffered instruction
if_ready  input  1  decode accepts the buffered instruction this cycle

Behaviour:
- Reset (sync, priority over everything):
  - pc = RESET_PC; state = IDLE; imem_req = 0; if_valid = 0; if_instr = NOP_INSTR; if_pc = 0; kill = 0; pend_pc = 0.
  - Reset during an outstanding fetch abandons it. An ack on the first cycle after reset is ignored.
- Target computation:
  - Branch: br_pc + {{19{im_in[12]}}, im_in}, modulo 2^32 (wraps past 32'hFFFF_FFFC).
  - jal: jal_target with bit 0 forced to 0.
- States:
  - IDLE: one cycle after reset, imem_req = 0, then go to FETCH.
  - FETCH: imem_req = 1, imem_addr = pc. Address held stable until imem_ack. Ack may arrive in the same cycle as req (zero wait).
    - On ack with kill = 0: if_instr = imem_rdata, if_pc = pc, if_valid = 1, pc += 4, go to HOLD.
  - HOLD: imem_req = 0. On if_valid && if_ready: if_valid = 0, if_instr = NOP_INSTR, go to FETCH.
  - Peak throughput is one instruction per 2 cycles.
- Redirect (pc_c = 1 or 2) has priority over normal flow:
  - IDLE or HOLD: pc = target; if_valid cleared, even if if_ready = 1 the same cycle (that instruction is squashed); go to FETCH next cycle.
  - FETCH with imem_ack in the same cycle: imem_rdata dropped; pc = target; stay in FETCH, so the new address is requested next cycle.
  - FETCH without ack: pend_pc = target, kill = 1, address unchanged. On the later ack: data dropped, pc = pend_pc, kill = 0, stay in FETCH.
  - Further redirects while kill = 1: pend_pc updated, latest wins. A redirect coincident with the killing ack wins over pend_pc.
- if_valid never asserts for a squashed fetch. pc_out always reflects the registered pc.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Adds output port if_misalign (1 bit, reset 0) and state HALT.
  - A redirect whose target has bit 1 set does not load pc. Instead: if_misalign = 1 (sticky), if_valid = 0, any outstanding fetch is killed, and the unit enters HALT.
  - HALT: imem_req = 0, all inputs ignored; only rst exits.
- Undefined: no port, no HALT state. Targets are used verbatim (bit 0 still cleared for jal), so imem_addr may have bit 1 set.

Test Plan:
- Reset with RESET_PC = 32'h100, zero-wait memory, if_ready = 1 -> imem_addr sequence 100, 104, 108 every 2 cycles; if_pc matches; if_valid pulses one cycle each.
- if_ready held 0 for 5 cycles after first ack -> HOLD, imem_req = 0, if_instr/if_pc stable (if_pc = 100); ready = 1 -> next fetch at 104.
- Memory with 3-cycle ack latency; branch pc_c = 2, br_pc = 32'h200, im_in = 13'h1FF8 (-8) in the 1st wait cycle -> that ack dropped, no if_valid; next imem_addr = 32'h1F8.
- jal pc_c = 1, jal_target = 32'h0000_0301 while in HOLD with if_ready = 1 -> buffered instruction squashed (if_valid 0 next cycle); next imem_addr = 32'h300.
- Two redirects during one pending fetch (targets 32'h400, then 32'h500) -> only 32'h500 fetched; branch with br_pc = 32'hFFFF_FFFC, im_in = 8 -> wraps to 32'h4.
- With MISALIGN_TRAP_EN: jal_target = 32'h0000_0402 -> if_misalign = 1, imem_req stays 0, pc unchanged; rst -> if_misalign = 0, pc = RESET_PC.
